// File: rtl/csr_pkg.sv
// Shared CSR map for accel_csr_v2: register offsets, STATUS/CTRL bit positions,
// configuration slot indices, the unmapped-access read pattern and common types.
package csr_pkg;

  localparam logic [31:0] OFF_CTRL        = 32'h0000_0000;
  localparam logic [31:0] OFF_IRQ_MASK    = 32'h0000_0004;
  localparam logic [31:0] OFF_CFG_BASE    = 32'h0000_0008;
  localparam logic [31:0] OFF_STATUS      = 32'h0000_003C;
  localparam logic [31:0] OFF_PERF_TOTAL  = 32'h0000_0040;
  localparam logic [31:0] OFF_PERF_ACTIVE = 32'h0000_0044;
  localparam logic [31:0] OFF_RESULT_BASE = 32'h0000_0080;

  // Configuration slots, in address order starting at OFF_CFG_BASE.
  localparam int NUM_CFG = 6;
  localparam int CFG_M   = 0;
  localparam int CFG_N   = 1;
  localparam int CFG_K   = 2;
  localparam int CFG_TM  = 3;
  localparam int CFG_TN  = 4;
  localparam int CFG_TK  = 5;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STS_BUSY        = 0;
  localparam int STS_DONE        = 1;
  localparam int STS_ERR_CRC     = 2;
  localparam int STS_ERR_ILLEGAL = 3;

  localparam logic [31:0] CSR_DEFAULT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_IRQ_MASK,
    SEL_CFG,
    SEL_STATUS,
    SEL_PERF_TOTAL,
    SEL_PERF_ACTIVE,
    SEL_RESULT
  } csr_sel_e;

  typedef enum logic {
    PERF_IDLE,
    PERF_RUN
  } perf_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/csr_perf_cnt.sv
// Run-time performance counters: total cycles and busy cycles of the current job,
// measured from an accepted start until a done pulse or an abort.
module csr_perf_cnt
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        busy_i,
  output logic [31:0] total_o,
  output logic [31:0] active_o
);

  perf_state_e state_q, state_d;
  logic [31:0] total_q, total_d;
  logic [31:0] active_q, active_d;

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    active_d = active_q;
    // A new start restarts the measurement even if a job is still being timed.
    if (start_i) begin
      state_d  = PERF_RUN;
      total_d  = '0;
      active_d = '0;
    end else if (state_q == PERF_RUN) begin
      if (stop_i) begin
        state_d = PERF_IDLE;
      end else begin
        total_d = sat_inc(total_q);
        if (busy_i) active_d = sat_inc(active_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PERF_IDLE;
      total_q  <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      active_q <= active_d;
    end
  end

  assign total_o  = total_q;
  assign active_o = active_q;

endmodule

// File: rtl/accel_csr_v2.sv
// accel_csr_v2: host CSR window for the accelerator - shadowed job configuration,
// start/abort control, sticky status + IRQ, result capture; perf counters with CSR_PERF_EN.
module accel_csr_v2
  import csr_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int NUM_RESULTS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csr_req,
  input  logic                      csr_we,
  input  logic [ADDR_W-1:0]         csr_addr,
  input  logic [31:0]               csr_wdata,
  output logic                      csr_ack,
  output logic                      csr_err,
  output logic [31:0]               csr_rdata,
  input  logic                      core_busy,
  input  logic                      core_done_tile_pulse,
  input  logic                      rx_crc_error,
  input  logic                      rx_illegal_cmd,
  input  logic [NUM_RESULTS*32-1:0] result_data,
  output logic                      start_pulse,
  output logic                      abort_pulse,
  output logic                      irq,
  output logic [31:0]               M,
  output logic [31:0]               N,
  output logic [31:0]               K,
  output logic [31:0]               Tm,
  output logic [31:0]               Tn,
  output logic [31:0]               Tk
);

  localparam int          RES_IW     = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
  localparam logic [31:0] CFG_END    = OFF_CFG_BASE + 32'(4 * NUM_CFG);
  localparam logic [31:0] RESULT_END = OFF_RESULT_BASE + 32'(4 * NUM_RESULTS);

  logic [31:0]       addr_ext;
  csr_sel_e          sel;
  logic [2:0]        cfg_idx;
  logic [RES_IW-1:0] res_idx;
  logic [31:0]       rd_data;
  logic [31:0]       perf_total;
  logic [31:0]       perf_active;

  logic [31:0] shadow_q  [NUM_CFG];
  logic [31:0] shadow_d  [NUM_CFG];
  logic [31:0] active_q  [NUM_CFG];
  logic [31:0] active_d  [NUM_CFG];
  logic [31:0] results_q [NUM_RESULTS];
  logic [31:0] results_d [NUM_RESULTS];

  logic [2:0]                      irq_mask_q, irq_mask_d;
  logic [STS_ERR_ILLEGAL:STS_DONE] sticky_q, sticky_d;
  logic                            irq_q, irq_d;
  logic                            start_pulse_q, start_pulse_d;
  logic                            abort_pulse_q, abort_pulse_d;
  logic                            ack_q, ack_d;
  logic                            err_q, err_d;
  logic [31:0]                     rdata_q, rdata_d;

  logic wr_en, ctrl_wr, cfg_wr, mask_wr, status_wr;
  logic abort_req, start_req, tiles_ok, start_ok, start_bad;

  // Address decode: alignment first, then each mapped window.
  always_comb begin
    // NOTE: every signal driven in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel      = SEL_NONE;
    cfg_idx  = '0;
    res_idx  = '0;
    addr_ext = 32'(csr_addr);
    if (addr_ext[1:0] == 2'b00) begin
      if (addr_ext == OFF_CTRL) begin
        sel = SEL_CTRL;
      end else if (addr_ext == OFF_IRQ_MASK) begin
        sel = SEL_IRQ_MASK;
      end else if (addr_ext >= OFF_CFG_BASE && addr_ext < CFG_END) begin
        sel     = SEL_CFG;
        cfg_idx = 3'((addr_ext - OFF_CFG_BASE) >> 2);
      end else if (addr_ext == OFF_STATUS) begin
        sel = SEL_STATUS;
      end else if (addr_ext == OFF_PERF_TOTAL) begin
        sel = SEL_PERF_TOTAL;
      end else if (addr_ext == OFF_PERF_ACTIVE) begin
        sel = SEL_PERF_ACTIVE;
      end else if (addr_ext >= OFF_RESULT_BASE && addr_ext < RESULT_END) begin
        sel     = SEL_RESULT;
        res_idx = RES_IW'((addr_ext - OFF_RESULT_BASE) >> 2);
      end
    end
  end

  always_comb begin
    rd_data = CSR_DEFAULT_RDATA;
    case (sel)
      SEL_CTRL:        rd_data = '0;
      SEL_IRQ_MASK:    rd_data = {29'd0, irq_mask_q};
      SEL_CFG:         rd_data = shadow_q[cfg_idx];
      SEL_STATUS:      rd_data = {28'd0, sticky_q, core_busy};
      SEL_PERF_TOTAL:  rd_data = perf_total;
      SEL_PERF_ACTIVE: rd_data = perf_active;
      SEL_RESULT:      rd_data = results_q[res_idx];
      default:         rd_data = CSR_DEFAULT_RDATA;
    endcase
  end

  assign wr_en     = csr_req & csr_we;
  assign ctrl_wr   = wr_en && (sel == SEL_CTRL);
  assign cfg_wr    = wr_en && (sel == SEL_CFG);
  assign mask_wr   = wr_en && (sel == SEL_IRQ_MASK);
  assign status_wr = wr_en && (sel == SEL_STATUS);

  // Abort dominates: a write carrying both bits is a plain abort, not an illegal start.
  assign abort_req = ctrl_wr & csr_wdata[CTRL_ABORT];
  assign start_req = ctrl_wr & csr_wdata[CTRL_START] & ~csr_wdata[CTRL_ABORT];
  assign tiles_ok  = (shadow_q[CFG_TM] != '0) && (shadow_q[CFG_TN] != '0) &&
                     (shadow_q[CFG_TK] != '0);
  assign start_ok  = start_req & ~core_busy & tiles_ok;
  assign start_bad = start_req & ~start_ok;

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    results_d  = results_q;
    irq_mask_d = irq_mask_q;
    sticky_d   = sticky_q;

    if (cfg_wr)    shadow_d[cfg_idx] = csr_wdata;
    if (mask_wr)   irq_mask_d = csr_wdata[2:0];
    if (status_wr) sticky_d = sticky_q & ~csr_wdata[STS_ERR_ILLEGAL:STS_DONE];

    // Sets are applied after the W1C so a same-cycle event always wins.
    if (core_done_tile_pulse)        sticky_d[STS_DONE]        = 1'b1;
    if (rx_crc_error)                sticky_d[STS_ERR_CRC]     = 1'b1;
    if (rx_illegal_cmd || start_bad) sticky_d[STS_ERR_ILLEGAL] = 1'b1;

    if (start_ok) active_d = shadow_q;
    if (core_done_tile_pulse) begin
      for (int i = 0; i < NUM_RESULTS; i++) results_d[i] = result_data[32*i +: 32];
    end

    start_pulse_d = start_ok;
    abort_pulse_d = abort_req;
    irq_d         = |(sticky_q & irq_mask_q);

    ack_d   = csr_req;
    err_d   = csr_req && (sel == SEL_NONE);
    rdata_d = csr_req ? rd_data : '0;
  end

`ifdef CSR_PERF_EN
  csr_perf_cnt u_perf_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_ok),
    .stop_i   (core_done_tile_pulse | abort_req),
    .busy_i   (core_busy),
    .total_o  (perf_total),
    .active_o (perf_active)
  );
`else
  assign perf_total  = '0;
  assign perf_active = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      start_pulse_q <= 1'b0;
      abort_pulse_q <= 1'b0;
      irq_q         <= 1'b0;
      irq_mask_q    <= '0;
      sticky_q      <= '0;
      // NOTE: these arrays are small flop-based register files that software can read
      // before any capture, so they are reset; a RAM-backed store would not be.
      for (int i = 0; i < NUM_CFG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int i = 0; i < NUM_RESULTS; i++) results_q[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples
      // the pre-edge value of every other flop, independent of statement order.
      ack_q         <= ack_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      start_pulse_q <= start_pulse_d;
      abort_pulse_q <= abort_pulse_d;
      irq_q         <= irq_d;
      irq_mask_q    <= irq_mask_d;
      sticky_q      <= sticky_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      results_q     <= results_d;
    end
  end

  assign csr_ack     = ack_q;
  assign csr_err     = err_q;
  assign csr_rdata   = rdata_q;
  assign start_pulse = start_pulse_q;
  assign abort_pulse = abort_pulse_q;
  assign irq         = irq_q;

  assign M  = active_q[CFG_M];
  assign N  = active_q[CFG_N];
  assign K  = active_q[CFG_K];
  assign Tm = active_q[CFG_TM];
  assign Tn = active_q[CFG_TN];
  assign Tk = active_q[CFG_TK];

endmodule

// File: tb/tb_accel_csr_v2.sv
// Self-checking bench for accel_csr_v2: directed scenarios plus randomized traffic,
// all compared against a register-level behavioural model of the CSR block.
module tb_accel_csr_v2;

  localparam int ADDR_W = 10;
  localparam int NR     = 8;
`ifdef CSR_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csr_req = 1'b0, csr_we = 1'b0;
  logic [ADDR_W-1:0] csr_addr = '0;
  logic [31:0]       csr_wdata = '0;
  logic              csr_ack, csr_err;
  logic [31:0]       csr_rdata;
  logic              core_busy = 1'b0, core_done_tile_pulse = 1'b0;
  logic              rx_crc_error = 1'b0, rx_illegal_cmd = 1'b0;
  logic [NR*32-1:0]  result_data = '0;
  logic              start_pulse, abort_pulse, irq;
  logic [31:0]       M, N, K, Tm, Tn, Tk;

  int n_run  = 0;
  int n_fail = 0;

  // Behavioural model of the programmer-visible state.
  logic [31:0] m_shadow [6];
  logic [31:0] m_active [6];
  logic [31:0] m_result [NR];
  logic [31:0] m_total, m_act;
  logic [2:0]  m_mask;
  bit          m_done, m_crc, m_ill, m_run;
  // Expectations for the cycle just clocked.
  logic        e_ack, e_err, e_start, e_abort, e_irq;
  logic [31:0] e_rdata;

  accel_csr_v2 #(.ADDR_W(ADDR_W), .NUM_RESULTS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_ack(csr_ack), .csr_err(csr_err), .csr_rdata(csr_rdata),
    .core_busy(core_busy), .core_done_tile_pulse(core_done_tile_pulse),
    .rx_crc_error(rx_crc_error), .rx_illegal_cmd(rx_illegal_cmd),
    .result_data(result_data),
    .start_pulse(start_pulse), .abort_pulse(abort_pulse), .irq(irq),
    .M(M), .N(N), .K(K), .Tm(Tm), .Tn(Tn), .Tk(Tk)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    for (int i = 0; i < NR; i++) m_result[i] = '0;
    m_total = '0; m_act = '0; m_mask = '0;
    m_done = 0; m_crc = 0; m_ill = 0; m_run = 0;
  endtask

  function automatic void model_read(input int unsigned a, output logic [31:0] d, output logic e);
    d = 32'hDEAD_BEEF;
    e = 1'b1;
    if (a % 4 == 0) begin
      e = 1'b0;
      if (a == 0)                      d = 32'd0;
      else if (a == 4)                 d = {29'd0, m_mask};
      else if (a >= 8 && a < 32)       d = m_shadow[(a - 8) / 4];
      else if (a == 'h3C)              d = {28'd0, m_ill, m_crc, m_done, core_busy};
      else if (a == 'h40)              d = PERF_EN ? m_total : 32'd0;
      else if (a == 'h44)              d = PERF_EN ? m_act : 32'd0;
      else if (a >= 'h80 && a < 'h80 + 4 * NR) d = m_result[(a - 'h80) / 4];
      else begin d = 32'hDEAD_BEEF; e = 1'b1; end
    end
  endfunction

  // Apply the current inputs to the model, then clock the DUT and settle.
  task automatic tick();
    int unsigned a;
    bit          start_acc, abort_w;
    logic [31:0] d;
    logic        e;
    a = csr_addr;
    e_ack = csr_req; e_rdata = '0; e_err = 1'b0;
    if (csr_req) begin model_read(a, d, e); e_rdata = d; e_err = e; end
    e_irq = |({m_ill, m_crc, m_done} & m_mask);
    start_acc = 0; abort_w = 0;
    if (csr_req && csr_we && a % 4 == 0) begin
      if (a == 0) begin
        if (csr_wdata[1]) abort_w = 1;
        else if (csr_wdata[0]) begin
          if (!core_busy && m_shadow[3] != 0 && m_shadow[4] != 0 && m_shadow[5] != 0) start_acc = 1;
          else m_ill = 1;
        end
      end else if (a == 4) m_mask = csr_wdata[2:0];
      else if (a >= 8 && a < 32) m_shadow[(a - 8) / 4] = csr_wdata;
      else if (a == 'h3C) begin
        if (csr_wdata[1]) m_done = 0;
        if (csr_wdata[2]) m_crc = 0;
        if (csr_wdata[3]) m_ill = 0;
      end
    end
    if (core_done_tile_pulse) m_done = 1;
    if (rx_crc_error) m_crc = 1;
    if (rx_illegal_cmd) m_ill = 1;
    if (core_done_tile_pulse) for (int i = 0; i < NR; i++) m_result[i] = result_data[32*i +: 32];
    if (PERF_EN) begin
      if (start_acc) begin m_run = 1; m_total = 0; m_act = 0; end
      else if (m_run) begin
        if (core_done_tile_pulse || abort_w) m_run = 0;
        else begin
          if (m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
          if (core_busy && m_act != 32'hFFFF_FFFF) m_act = m_act + 1;
        end
      end
    end
    if (start_acc) for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
    e_start = start_acc;
    e_abort = abort_w;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_op(input bit we, input int unsigned addr, input logic [31:0] wdata);
    csr_req = 1'b1; csr_we = we; csr_addr = ADDR_W'(addr); csr_wdata = wdata;
    tick();
    csr_req = 1'b0; csr_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_run++; if ({csr_ack, csr_err, start_pulse, abort_pulse, irq} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b exp 00000", {csr_ack, csr_err, start_pulse, abort_pulse, irq}); end
    n_run++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", csr_rdata); end
    n_run++; if ({M, N, K, Tm, Tn, Tk} !== 192'd0) begin n_fail++; $display("FAIL reset_cfg: M=%0d Tm=%0d Tk=%0d exp 0", M, Tm, Tk); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    begin
      int unsigned al[5] = '{'h3C, 'h04, 'h1C, 'h40, 'h80};
      foreach (al[i]) begin
        csr_op(0, al[i], 0);
        n_run++; if (csr_rdata !== 32'd0 || csr_err !== 1'b0) begin n_fail++; $display("FAIL reset_read_%h: got %h err %b exp 0 err 0", al[i], csr_rdata, csr_err); end
      end
    end
  endtask

  task automatic test_start();
    int unsigned al[4] = '{'h14, 'h18, 'h1C, 'h08};
    logic [31:0] dl[4] = '{32'd4, 32'd4, 32'd4, 32'd16};
    core_busy = 1'b0;
    foreach (al[i]) begin
      csr_op(1, al[i], dl[i]);
      n_run++; if (csr_ack !== 1'b1 || csr_err !== 1'b0) begin n_fail++; $display("FAIL start_cfg_ack_%h: ack %b err %b exp 1 0", al[i], csr_ack, csr_err); end
    end
    n_run++; if (M !== 32'd0) begin n_fail++; $display("FAIL start_shadow_only: M=%0d exp 0", M); end
    csr_op(1, 'h00, 32'd1);
    n_run++; if (start_pulse !== 1'b1 || start_pulse !== e_start) begin n_fail++; $display("FAIL start_pulse: got %b exp 1", start_pulse); end
    n_run++; if (M !== 32'd16 || Tk !== 32'd4) begin n_fail++; $display("FAIL start_commit: M=%0d Tk=%0d exp 16 4", M, Tk); end
    n_run++; if (csr_ack !== 1'b1) begin n_fail++; $display("FAIL start_ctrl_ack: got %b exp 1", csr_ack); end
    tick();
    n_run++; if (start_pulse !== 1'b0 || csr_ack !== 1'b0) begin n_fail++; $display("FAIL start_single: pulse %b ack %b exp 0 0", start_pulse, csr_ack); end
  endtask

  task automatic test_reject();
    csr_op(1, 'h1C, 32'd0);
    csr_op(1, 'h00, 32'd1);
    n_run++; if (start_pulse !== 1'b0) begin n_fail++; $display("FAIL reject_pulse: got %b exp 0", start_pulse); end
    n_run++; if (Tk !== 32'd4) begin n_fail++; $display("FAIL reject_active: Tk=%0d exp 4", Tk); end
    csr_op(0, 'h3C, 0);
    n_run++; if (csr_rdata !== 32'h8 || csr_rdata !== e_rdata) begin n_fail++; $display("FAIL reject_status: got %h exp 8", csr_rdata); end
    csr_op(1, 'h3C, 32'h8);
    csr_op(0, 'h3C, 0);
    n_run++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL reject_w1c: got %h exp 0", csr_rdata); end
    csr_op(1, 'h00, 32'h3);
    n_run++; if (abort_pulse !== 1'b1 || start_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_both: abort %b start %b exp 1 0", abort_pulse, start_pulse); end
    csr_op(0, 'h3C, 0);
    n_run++; if (csr_rdata !== 32'h0 || abort_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_no_err: status %h abort %b exp 0 0", csr_rdata, abort_pulse); end
    csr_op(1, 'h1C, 32'd4);
  endtask

  task automatic test_irq();
    csr_op(1, 'h04, 32'h1);
    tick();
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b exp 0", irq); end
    for (int i = 0; i < NR; i++) result_data[32*i +: 32] = $urandom;
    core_done_tile_pulse = 1'b1; tick(); core_done_tile_pulse = 1'b0;
    n_run++; if (irq !== 1'b0 || irq !== e_irq) begin n_fail++; $display("FAIL irq_latency: got %b exp 0", irq); end
    tick();
    n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b exp 1", irq); end
    core_done_tile_pulse = 1'b1;
    csr_op(1, 'h3C, 32'h2);
    core_done_tile_pulse = 1'b0;
    csr_op(0, 'h3C, 0);
    n_run++; if (csr_rdata !== 32'h2 || csr_rdata !== e_rdata) begin n_fail++; $display("FAIL irq_set_wins: status %h exp 2", csr_rdata); end
    n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b exp 1", irq); end
    csr_op(1, 'h3C, 32'h2);
    repeat (2) tick();
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b exp 0", irq); end
  endtask

  task automatic test_perf();
    core_busy = 1'b0;
    csr_op(1, 'h00, 32'd1);
    n_run++; if (start_pulse !== 1'b1) begin n_fail++; $display("FAIL perf_start: got %b exp 1", start_pulse); end
    core_busy = 1'b1; repeat (10) tick();
    core_busy = 1'b0; repeat (2) tick();
    core_done_tile_pulse = 1'b1; tick(); core_done_tile_pulse = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      csr_op(0, 'h40, 0);
      n_run++; if (csr_rdata !== (PERF_EN ? 32'd12 : 32'd0) || csr_rdata !== e_rdata || csr_err !== 1'b0) begin n_fail++; $display("FAIL perf_total_%0d: got %0d err %b exp %0d", pass, csr_rdata, csr_err, e_rdata); end
      csr_op(0, 'h44, 0);
      n_run++; if (csr_rdata !== (PERF_EN ? 32'd10 : 32'd0) || csr_rdata !== e_rdata || csr_err !== 1'b0) begin n_fail++; $display("FAIL perf_active_%0d: got %0d err %b exp %0d", pass, csr_rdata, csr_err, e_rdata); end
      core_busy = 1'b1; repeat (5) tick(); core_busy = 1'b0;
    end
  endtask

  task automatic test_results();
    logic [31:0] r7, r4;
    for (int i = 0; i < NR; i++) result_data[32*i +: 32] = $urandom;
    r7 = result_data[255:224];
    r4 = result_data[159:128];
    core_done_tile_pulse = 1'b1; tick(); core_done_tile_pulse = 1'b0;
    result_data = ~result_data;
    csr_op(0, 'h9C, 0);
    n_run++; if (csr_rdata !== r7 || csr_err !== 1'b0) begin n_fail++; $display("FAIL result7: got %h err %b exp %h", csr_rdata, csr_err, r7); end
    csr_op(0, 'h90, 0);
    n_run++; if (csr_rdata !== r4) begin n_fail++; $display("FAIL result4: got %h exp %h", csr_rdata, r4); end
    csr_op(0, 'hA0, 0);
    n_run++; if (csr_rdata !== 32'hDEAD_BEEF || csr_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_a0: got %h err %b exp deadbeef 1", csr_rdata, csr_err); end
    csr_op(0, 'h02, 0);
    n_run++; if (csr_rdata !== 32'hDEAD_BEEF || csr_err !== 1'b1) begin n_fail++; $display("FAIL unaligned_02: got %h err %b exp deadbeef 1", csr_rdata, csr_err); end
    csr_op(1, 'h0A, 32'h1234_5678);
    n_run++; if (csr_err !== 1'b1) begin n_fail++; $display("FAIL unaligned_wr_err: got %b exp 1", csr_err); end
    csr_op(0, 'h08, 0);
    n_run++; if (csr_rdata !== 32'd16) begin n_fail++; $display("FAIL unaligned_wr_effect: M shadow %h exp 10", csr_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    v = $urandom | 32'h1;
    csr_op(0, 'h0C, 0);
    n_run++; if (csr_rdata !== m_shadow[1] && csr_ack === 1'b1) begin n_fail++; $display("FAIL b2b_pre: got %h exp %h", csr_rdata, m_shadow[1]); end
    csr_op(1, 'h0C, v);
    n_run++; if (csr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ack: got %b exp 1", csr_ack); end
    csr_op(0, 'h0C, 0);
    n_run++; if (csr_rdata !== v || csr_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_new: got %h ack %b exp %h 1", csr_rdata, csr_ack, v); end
    n_run++; if (N !== m_active[1]) begin n_fail++; $display("FAIL b2b_active: N=%h exp %h", N, m_active[1]); end
  endtask

  task automatic test_reset_midrun();
    core_busy = 1'b0;
    csr_req = 1'b1; csr_we = 1'b1; csr_addr = '0; csr_wdata = 32'd1;
    #3 rst_n = 1'b0;
    #1;
    n_run++; if ({csr_ack, csr_err, start_pulse, abort_pulse, irq} !== 5'b0 || csr_rdata !== 32'd0 || {M, Tk} !== 64'd0) begin n_fail++; $display("FAIL midrun_in_reset: ack %b pulse %b rdata %h M %0d", csr_ack, start_pulse, csr_rdata, M); end
    @(posedge clk); #1;
    csr_req = 1'b0; csr_we = 1'b0;
    n_run++; if (start_pulse !== 1'b0 || csr_ack !== 1'b0) begin n_fail++; $display("FAIL midrun_dropped: pulse %b ack %b exp 0 0", start_pulse, csr_ack); end
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    csr_op(1, 'h14, 32'd2); csr_op(1, 'h18, 32'd2); csr_op(1, 'h1C, 32'd2);
    csr_op(1, 'h00, 32'd1);
    n_run++; if (start_pulse !== 1'b1 || Tm !== 32'd2) begin n_fail++; $display("FAIL midrun_restart: pulse %b Tm %0d exp 1 2", start_pulse, Tm); end
    #2 rst_n = 1'b0;
    #1;
    n_run++; if (start_pulse !== 1'b0 || csr_ack !== 1'b0 || Tm !== 32'd0) begin n_fail++; $display("FAIL midrun_async: pulse %b ack %b Tm %0d exp 0 0 0", start_pulse, csr_ack, Tm); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int unsigned al[17] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h3C,
                            'h40, 'h44, 'h80, 'h9C, 'hA0, 'h02, 'h20, 'h3FC};
    int unsigned a;
    bit          rd;
    for (int c = 0; c < 400; c++) begin
      core_busy            = ($urandom_range(0, 3) == 0);
      core_done_tile_pulse = ($urandom_range(0, 15) == 0);
      rx_crc_error         = ($urandom_range(0, 31) == 0);
      rx_illegal_cmd       = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NR; i++) result_data[32*i +: 32] = $urandom;
      a = al[$urandom_range(0, 16)];
      csr_req   = ($urandom_range(0, 3) != 0);
      csr_we    = $urandom_range(0, 1);
      csr_addr  = ADDR_W'(a);
      if (a == 0)          csr_wdata = $urandom_range(0, 3);
      else if (a == 'h3C)  csr_wdata = $urandom_range(0, 15);
      else if (a == 'h04)  csr_wdata = $urandom_range(0, 7);
      else                 csr_wdata = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      rd = csr_req && !csr_we;
      tick();
      n_run++; if (csr_ack !== e_ack || csr_err !== e_err) begin n_fail++; $display("FAIL rnd_ack_%0d: ack %b err %b exp %b %b", c, csr_ack, csr_err, e_ack, e_err); end
      if (rd) begin
        n_run++; if (csr_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata_%0d addr %h: got %h exp %h", c, a, csr_rdata, e_rdata); end
      end
      n_run++; if ({start_pulse, abort_pulse, irq} !== {e_start, e_abort, e_irq}) begin n_fail++; $display("FAIL rnd_pulses_%0d: got %b exp %b", c, {start_pulse, abort_pulse, irq}, {e_start, e_abort, e_irq}); end
      n_run++; if ({M, N, K, Tm, Tn, Tk} !== {m_active[0], m_active[1], m_active[2], m_active[3], m_active[4], m_active[5]}) begin n_fail++; $display("FAIL rnd_cfg_%0d: M %h Tk %h exp %h %h", c, M, Tk, m_active[0], m_active[5]); end
    end
    csr_req = 1'b0; csr_we = 1'b0; core_busy = 1'b0; core_done_tile_pulse = 1'b0;
    rx_crc_error = 1'b0; rx_illegal_cmd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_reject();
    test_irq();
    test_perf();
    test_results();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
